// File: rtl/fetch_queue.sv
// Fetch queue: a circular buffer between instruction memory and the issue controller.
// Optional saturating statistics counters are built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue #(
    parameter int FETCH_WIDTH = 8,
    parameter int ISSUE_WIDTH = 8,
    parameter int DEPTH       = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               enq_valid,
    input  logic [31:0]                        enq_pc,
    input  logic [$clog2(FETCH_WIDTH):0]       enq_count,
    input  logic [FETCH_WIDTH*32-1:0]          enq_instr,
    output logic                               enq_ready,
    output logic [$clog2(ISSUE_WIDTH):0]       deq_avail,
    output logic [ISSUE_WIDTH*32-1:0]          deq_instr,
    output logic [ISSUE_WIDTH*32-1:0]          deq_pc,
    input  logic [$clog2(ISSUE_WIDTH):0]       deq_count,
    output logic [$clog2(DEPTH):0]             count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]                        stat_stall_cycles,
    output logic [31:0]                        stat_empty_cycles,
    output logic [31:0]                        stat_flushes
`endif
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int FCW  = $clog2(FETCH_WIDTH) + 1;
    localparam int ICW  = $clog2(ISSUE_WIDTH) + 1;

    generate
        if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < FETCH_WIDTH + ISSUE_WIDTH)) begin : g_bad_depth
            $error("fetch_queue: DEPTH must be a power of two and >= FETCH_WIDTH+ISSUE_WIDTH");
        end
    endgenerate

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            enq_fire;
    logic [FCW-1:0]  enq_n;
    logic [FCW-1:0]  enq_add;
    logic [ICW-1:0]  deq_n;

    // Handshake: enq_ready is a function of the registered count only; a group offered
    // while enq_ready is low is dropped and must be re-offered. The consumer takes
    // deq_count entries from the head window; a request beyond deq_avail is clamped.
    always_comb begin
        enq_ready = (count <= CNTW'(DEPTH - FETCH_WIDTH));
        enq_fire  = enq_valid && enq_ready && !flush;
        enq_n     = (enq_count > FCW'(FETCH_WIDTH)) ? FCW'(FETCH_WIDTH) : enq_count;
        enq_add   = enq_fire ? enq_n : '0;
        deq_avail = (count > CNTW'(ISSUE_WIDTH)) ? ICW'(ISSUE_WIDTH) : ICW'(count);
        deq_n     = (deq_count > deq_avail) ? deq_avail : deq_count;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_add);
            count <= count + CNTW'(enq_add) - CNTW'(deq_n);
        end
    end

    // Entry storage has no reset; pointer arithmetic wraps modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (enq_fire && (k < int'(enq_n))) begin
                instr_mem[tail + PW'(k)] <= enq_instr[32*k +: 32];
                pc_mem[tail + PW'(k)]    <= enq_pc + 32'(4 * k);
            end
        end
    end

    always_comb begin
        deq_instr = '0;
        deq_pc    = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            if (j < int'(deq_avail)) begin
                deq_instr[32*j +: 32] = instr_mem[head + PW'(j)];
                deq_pc[32*j +: 32]    = pc_mem[head + PW'(j)];
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_empty_cycles <= '0;
            stat_flushes      <= '0;
        end else begin
            if (enq_valid && !enq_ready && (stat_stall_cycles != 32'hFFFF_FFFF))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if ((count == '0) && (stat_empty_cycles != 32'hFFFF_FFFF))
                stat_empty_cycles <= stat_empty_cycles + 32'd1;
            if (flush && (stat_flushes != 32'hFFFF_FFFF))
                stat_flushes <= stat_flushes + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (deq_count <= deq_avail)
                else $warning("fetch_queue: deq_count %0d above deq_avail %0d, clamped", deq_count, deq_avail);
        end
        if (!rst) begin
            assert (count <= CNTW'(DEPTH))
                else $error("fetch_queue: occupancy %0d exceeds DEPTH", count);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: reset, fill/drop, steady state with wrap,
// dequeue clamping, pointer wrap straddle, flush and (optionally) statistics.
module tb_fetch_queue;

    localparam int FW    = 8;
    localparam int IW    = 8;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              enq_valid;
    logic [31:0]       enq_pc;
    logic [3:0]        enq_count;
    logic [FW*32-1:0]  enq_instr;
    logic              enq_ready;
    logic [3:0]        deq_avail;
    logic [IW*32-1:0]  deq_instr;
    logic [IW*32-1:0]  deq_pc;
    logic [3:0]        deq_count;
    logic [5:0]        count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]       stat_stall_cycles;
    logic [31:0]       stat_empty_cycles;
    logic [31:0]       stat_flushes;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_count (enq_count),
        .enq_instr (enq_instr),
        .enq_ready (enq_ready),
        .deq_avail (deq_avail),
        .deq_instr (deq_instr),
        .deq_pc    (deq_pc),
        .deq_count (deq_count),
        .count     (count)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_empty_cycles (stat_empty_cycles),
        .stat_flushes      (stat_flushes)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        enq_valid = 1'b0;
        enq_count = 4'd0;
        deq_count = 4'd0;
        flush     = 1'b0;
    endtask

    task automatic load_group(input logic [31:0] pc, input logic [31:0] ibase, input int cnt);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_count = 4'(cnt);
        for (int k = 0; k < FW; k++) enq_instr[32*k +: 32] = ibase + 32'(k);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        enq_pc    = '0;
        enq_instr = '0;
        do_reset();
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        n_cmp++; if (deq_avail !== 4'd0) begin n_bad++; $display("FAIL reset_deq_avail: got %0d expected 0", deq_avail); end
        n_cmp++; if (deq_instr !== '0) begin n_bad++; $display("FAIL reset_deq_instr: got %h expected 0", deq_instr); end
        n_cmp++; if (deq_pc !== '0) begin n_bad++; $display("FAIL reset_deq_pc: got %h expected 0", deq_pc); end
    endtask

    task automatic test_single_enq();
        load_group(32'h3000, 32'h1000, 8);
        step();
        drive_idle();
        n_cmp++; if (count !== 6'd8) begin n_bad++; $display("FAIL single_count: got %0d expected 8", count); end
        n_cmp++; if (deq_avail !== 4'd8) begin n_bad++; $display("FAIL single_avail: got %0d expected 8", deq_avail); end
        n_cmp++; if (deq_pc[31:0] !== 32'h3000) begin n_bad++; $display("FAIL single_pc0: got %h expected 3000", deq_pc[31:0]); end
        n_cmp++; if (deq_pc[7*32 +: 32] !== 32'h301C) begin n_bad++; $display("FAIL single_pc7: got %h expected 301c", deq_pc[7*32 +: 32]); end
        n_cmp++; if (deq_instr[3*32 +: 32] !== 32'h1003) begin n_bad++; $display("FAIL single_instr3: got %h expected 1003", deq_instr[3*32 +: 32]); end
        // zero-count group is a no-op
        load_group(32'h5555, 32'h5555, 0);
        step();
        drive_idle();
        n_cmp++; if (count !== 6'd8) begin n_bad++; $display("FAIL zero_count_noop: got %0d expected 8", count); end
    endtask

    task automatic test_fill_drop();
        load_group(32'h3020, 32'h1008, 8); step();
        load_group(32'h3040, 32'h1010, 8); step();
        drive_idle();
        n_cmp++; if (count !== 6'd24) begin n_bad++; $display("FAIL fill_count24: got %0d expected 24", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_at24: got %b expected 1", enq_ready); end
        load_group(32'h3060, 32'h1018, 8); step();
        drive_idle();
        n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL fill_count32: got %0d expected 32", count); end
        n_cmp++; if (enq_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_full: got %b expected 0", enq_ready); end
        load_group(32'h4000, 32'h9000, 8); step();
        drive_idle();
        n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL drop_count: got %0d expected 32", count); end
        n_cmp++; if (deq_pc[31:0] !== 32'h3000) begin n_bad++; $display("FAIL drop_pc0: got %h expected 3000", deq_pc[31:0]); end
        n_cmp++; if (deq_instr[31:0] !== 32'h1000) begin n_bad++; $display("FAIL drop_instr0: got %h expected 1000", deq_instr[31:0]); end
    endtask

    task automatic test_steady();
        int          exp_cnt [13] = '{8, 13, 18, 23, 28, 25, 22, 27, 24, 29, 26, 23, 28};
        bit          acc     [13] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1};
        int          exp_deq [13] = '{0, 3, 6, 9, 12, 15, 18, 21, 24, 27, 30, 33, 36};
        int          sent;
        logic [31:0] pc;
        logic [31:0] hpc;
        do_reset();
        sent = 0;
        for (int i = 0; i < 13; i++) begin
            pc = 32'h5000 + 32'(32 * sent);
            enq_valid = 1'b1;
            enq_count = 4'd8;
            enq_pc    = pc;
            for (int k = 0; k < FW; k++) enq_instr[32*k +: 32] = 32'hA000_0000 | (pc + 32'(4 * k));
            deq_count = 4'd3;
            step();
            if (acc[i]) sent++;
            hpc = 32'h5000 + 32'(4 * exp_deq[i]);
            n_cmp++; if (count !== 6'(exp_cnt[i])) begin n_bad++; $display("FAIL steady_count[%0d]: got %0d expected %0d", i, count, exp_cnt[i]); end
            n_cmp++; if (enq_ready !== (exp_cnt[i] <= 24)) begin n_bad++; $display("FAIL steady_ready[%0d]: got %b expected %b", i, enq_ready, exp_cnt[i] <= 24); end
            n_cmp++; if (deq_pc[31:0] !== hpc) begin n_bad++; $display("FAIL steady_pc0[%0d]: got %h expected %h", i, deq_pc[31:0], hpc); end
            n_cmp++; if (deq_pc[7*32 +: 32] !== hpc + 32'd28) begin n_bad++; $display("FAIL steady_pc7[%0d]: got %h expected %h", i, deq_pc[7*32 +: 32], hpc + 32'd28); end
            n_cmp++; if (deq_instr[7*32 +: 32] !== (32'hA000_0000 | (hpc + 32'd28))) begin n_bad++; $display("FAIL steady_instr7[%0d]: got %h expected %h", i, deq_instr[7*32 +: 32], 32'hA000_0000 | (hpc + 32'd28)); end
        end
        drive_idle();
    endtask

    task automatic test_clamp();
        do_reset();
        load_group(32'h6000, 32'h6000, 5);
        step();
        drive_idle();
        n_cmp++; if (count !== 6'd5) begin n_bad++; $display("FAIL clamp_pre_count: got %0d expected 5", count); end
        n_cmp++; if (deq_avail !== 4'd5) begin n_bad++; $display("FAIL clamp_pre_avail: got %0d expected 5", deq_avail); end
        n_cmp++; if (deq_pc[4*32 +: 32] !== 32'h6010) begin n_bad++; $display("FAIL clamp_pre_pc4: got %h expected 6010", deq_pc[4*32 +: 32]); end
        n_cmp++; if (deq_pc[5*32 +: 32] !== 32'h0) begin n_bad++; $display("FAIL clamp_pre_pc5_zero: got %h expected 0", deq_pc[5*32 +: 32]); end
        deq_count = 4'd8;
        step();
        drive_idle();
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL clamp_count: got %0d expected 0", count); end
        n_cmp++; if (deq_avail !== 4'd0) begin n_bad++; $display("FAIL clamp_avail: got %0d expected 0", deq_avail); end
        n_cmp++; if (deq_instr !== '0) begin n_bad++; $display("FAIL clamp_instr_zero: got %h expected 0", deq_instr); end
        n_cmp++; if (deq_pc !== '0) begin n_bad++; $display("FAIL clamp_pc_zero: got %h expected 0", deq_pc); end
    endtask

    // Starts with head=tail=5, so the fourth group straddles index 31 -> 0.
    task automatic test_wrap();
        for (int g = 0; g < 4; g++) begin
            load_group(32'h7000 + 32'(32 * g), 32'h2000 + 32'(8 * g), 8);
            step();
        end
        drive_idle();
        n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL wrap_count32: got %0d expected 32", count); end
        deq_count = 4'd8;
        step(); step(); step();
        drive_idle();
        n_cmp++; if (count !== 6'd8) begin n_bad++; $display("FAIL wrap_count8: got %0d expected 8", count); end
        n_cmp++; if (deq_pc[31:0] !== 32'h7060) begin n_bad++; $display("FAIL wrap_pc0: got %h expected 7060", deq_pc[31:0]); end
        n_cmp++; if (deq_pc[7*32 +: 32] !== 32'h707C) begin n_bad++; $display("FAIL wrap_pc7: got %h expected 707c", deq_pc[7*32 +: 32]); end
        n_cmp++; if (deq_instr[3*32 +: 32] !== 32'h201B) begin n_bad++; $display("FAIL wrap_instr3: got %h expected 201b", deq_instr[3*32 +: 32]); end
        n_cmp++; if (deq_instr[7*32 +: 32] !== 32'h201F) begin n_bad++; $display("FAIL wrap_instr7: got %h expected 201f", deq_instr[7*32 +: 32]); end
    endtask

    task automatic test_flush();
        load_group(32'h8000, 32'h3000, 8); step();
        load_group(32'h8020, 32'h3008, 4); step();
        drive_idle();
        n_cmp++; if (count !== 6'd20) begin n_bad++; $display("FAIL flush_pre_count: got %0d expected 20", count); end
        load_group(32'h9000, 32'h9000, 8);
        deq_count = 4'd4;
        flush     = 1'b1;
        step();
        drive_idle();
        n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b expected 1", enq_ready); end
        n_cmp++; if (deq_avail !== 4'd0) begin n_bad++; $display("FAIL flush_avail: got %0d expected 0", deq_avail); end
        n_cmp++; if (deq_pc !== '0) begin n_bad++; $display("FAIL flush_pc_zero: got %h expected 0", deq_pc); end
        load_group(32'h3400, 32'h4400, 8);
        step();
        drive_idle();
        n_cmp++; if (count !== 6'd8) begin n_bad++; $display("FAIL post_flush_count: got %0d expected 8", count); end
        n_cmp++; if (deq_pc[31:0] !== 32'h3400) begin n_bad++; $display("FAIL post_flush_pc0: got %h expected 3400", deq_pc[31:0]); end
        n_cmp++; if (deq_instr[31:0] !== 32'h4400) begin n_bad++; $display("FAIL post_flush_instr0: got %h expected 4400", deq_instr[31:0]); end
    endtask

`ifdef FETCH_QUEUE_STATS_EN
    task automatic test_stats();
        do_reset();
        n_cmp++; if (stat_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL stats_reset_stall: got %0d expected 0", stat_stall_cycles); end
        for (int g = 0; g < 4; g++) begin
            load_group(32'hB000 + 32'(32 * g), 32'hC000, 8);
            step();
        end
        step(); step(); step();
        drive_idle();
        n_cmp++; if (stat_stall_cycles !== 32'd3) begin n_bad++; $display("FAIL stats_stall: got %0d expected 3", stat_stall_cycles); end
        flush = 1'b1;
        step(); step();
        drive_idle();
        n_cmp++; if (stat_flushes !== 32'd2) begin n_bad++; $display("FAIL stats_flushes: got %0d expected 2", stat_flushes); end
        n_cmp++; if (stat_empty_cycles !== 32'd2) begin n_bad++; $display("FAIL stats_empty: got %0d expected 2", stat_empty_cycles); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (stat_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL stats_rst_stall: got %0d expected 0", stat_stall_cycles); end
        n_cmp++; if (stat_flushes !== 32'd0) begin n_bad++; $display("FAIL stats_rst_flushes: got %0d expected 0", stat_flushes); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_enq();
        test_fill_drop();
        test_steady();
        test_clamp();
        test_wrap();
        test_flush();
`ifdef FETCH_QUEUE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between instruction_memory and issue_controller.
- Accepts up to FETCH_WIDTH instructions per cycle, each tagged with its PC.
- Presents a head window of up to ISSUE_WIDTH in-order instructions; the issue controller consumes a variable number per cycle.
- Flushed on rollback or PC redirect; the PC-steering logic stays in issue_controller.

Parameters:
- FETCH_WIDTH, 8, max instructions enqueued per cycle.
- ISSUE_WIDTH, 8, max instructions presented/dequeued per cycle.
- DEPTH, 32, entries; power of two and at least FETCH_WIDTH+ISSUE_WIDTH (elaboration error otherwise).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries (rollback/redirect).
- enq_valid  in  1  fetch group present.
- enq_pc  in  32  byte PC of slot 0 of the group.
- enq_count  in  $clog2(FETCH_WIDTH)+1  number of valid slots, from slot 0 upward.
- enq_instr  in  FETCH_WIDTH*32  packed instructions; slot k at bits [32k+31:32k].
- enq_ready  out  1  queue can take a full group this cycle.
- deq_avail  out  $clog2(ISSUE_WIDTH)+1  min(count, ISSUE_WIDTH).
- deq_instr  out  ISSUE_WIDTH*32  head window; slot 0 is the oldest entry.
- deq_pc  out  ISSUE_WIDTH*32  PC of each head-window slot.
- deq_count  in  $clog2(ISSUE_WIDTH)+1  entries consumed this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: entry arrays instr[DEPTH] and pc[DEPTH]; head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy count.
- Reset (rst=1 at edge): head=tail=count=0. Entry contents need not be cleared.
- Outputs after reset: enq_ready=1, deq_avail=0, deq_instr=0, deq_pc=0.
- enq_ready = (DEPTH - count) >= FETCH_WIDTH. Computed combinationally from the registered count only; independent of same-cycle deq_count.
- Enqueue fires when enq_valid && enq_ready && !flush. Let n = min(enq_count, FETCH_WIDTH):
  - for k < n: entry[(tail+k) mod DEPTH] <= {enq_instr slot k, enq_pc + 4k};
  - tail += n.
  - n=0 is a no-op.
- enq_valid while enq_ready=0: group is dropped and the queue is unchanged. The caller must hold imem_addr.
- Head window, combinational from registered state:
  - slot j < deq_avail shows entry[(head+j) mod DEPTH];
  - slots j >= deq_avail drive 0 on both deq_instr and deq_pc.
- Dequeue: d = min(deq_count, deq_avail); head += d. A deq_count above deq_avail is clamped, and a simulation-only assertion fires.
- Simultaneous enqueue and dequeue: count_next = count + n - d. A dequeue never sees the same-cycle enqueue (zero bypass); enqueue-to-visible latency is 1 cycle.
- Flush: highest priority after rst. Next cycle head=tail=count=0, and same-cycle enqueue and dequeue are ignored. Next cycle deq_avail=0, enq_ready=1.
- Wrap-around: a group straddling index DEPTH-1 → 0 is written contiguously modulo DEPTH. The head window likewise reads across the wrap.
- count never exceeds DEPTH by construction; a simulation assertion covers it.
- Full: count > DEPTH-FETCH_WIDTH gives enq_ready=0.
- Empty: deq_avail=0 and window all zero.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- When defined, the block adds three 32-bit outputs, each reset to 0 and cleared by rst only, not by flush:
  - stat_stall_cycles: increments each cycle enq_valid=1 && enq_ready=0.
  - stat_empty_cycles: increments each cycle count=0.
  - stat_flushes: increments on each flush.
- All three counters saturate at 32'hFFFF_FFFF.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then one enqueue of enq_count=8, enq_pc=0x3000, instr slot k = 0x1000+k, with deq_count=0 → next cycle count=8, deq_avail=8, deq_pc[0]=0x3000, deq_pc[7]=0x301C, deq_instr[3]=0x1003.
- Four full groups with no dequeue → count=32, enq_ready=0. A fifth enqueue is dropped: count stays 32 and the window still starts at the first group.
- Steady state with enqueue 8 and deq_count=3 each cycle → count grows by 5 per cycle until enq_ready drops. When the head wraps past index 31 to 0, PCs in the window remain consecutive (+4).
- count=5 with deq_count=8 → d clamped to 5, count=0, deq_avail=0, window all zero, assertion logged.
- count=20 with flush=1, enq_valid=1 and deq_count=4 in the same cycle → next cycle count=0, enq_ready=1. A subsequent enqueue with enq_pc=0x3400 appears at slot 0.
- With FETCH_QUEUE_STATS_EN defined: 3 stalled enqueue cycles and 2 flushes → stat_stall_cycles=3, stat_flushes=2. Reset returns both to 0.
